// File: rtl/mem_write_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_write_ctrl: store buffer that lane-aligns core stores into a FIFO,
// drains them as memory write beats and flags read-after-write hazards.
// Revision: 1.0
// ---------------------------------------------------------------------------
module mem_write_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      st_valid,
  output logic                      st_ready,
  input  logic [ADDR_WIDTH-1:0]     st_addr,
  input  logic [DATA_WIDTH-1:0]     st_data,
  input  logic [1:0]                st_size,
  output logic                      st_misaligned,
  output logic                      wr_en,
  input  logic                      wr_ready,
  output logic [ADDR_WIDTH-1:0]     wr_addr,
  output logic [DATA_WIDTH-1:0]     wr_data,
  output logic [DATA_WIDTH/8-1:0]   wr_strb,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  output logic                      rd_hazard,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int STRB_W = DATA_WIDTH / 8;

  generate
    if (DATA_WIDTH != 32 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
      $error("mem_write_ctrl: DATA_WIDTH must be 32 and DEPTH a power of 2 >= 2");
    end
  endgenerate

  logic [PTR_W-1:0]      wptr_q, rptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  mis_q;
  logic [ADDR_WIDTH-1:0] buf_addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] buf_data_q [DEPTH];
  logic [STRB_W-1:0]     buf_strb_q [DEPTH];

  logic                  accept, illegal, push, pop;
  logic [1:0]            off;
  logic [ADDR_WIDTH-1:0] ent_addr, rd_word;
  logic [DATA_WIDTH-1:0] ent_data;
  logic [STRB_W-1:0]     ent_strb;
  logic [PTR_W-1:0]      rel [DEPTH];
  logic [DEPTH-1:0]      entry_valid;

  assign off      = st_addr[1:0];
  assign st_ready = (count_q < CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign wr_en    = !empty;
  assign accept   = st_valid && st_ready;
  assign push     = accept && !illegal;
  assign pop      = wr_en && wr_ready;
  assign ent_addr = {st_addr[ADDR_WIDTH-1:2], 2'b00};
  assign rd_word  = {rd_addr[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    illegal  = 1'b0;
    ent_strb = 4'b1111;
    ent_data = st_data;
    case (st_size)
      2'b00: begin
        ent_strb = 4'b0001 << off;
        ent_data = {4{st_data[7:0]}};
      end
      2'b01: begin
        illegal  = off[0];
        ent_strb = 4'b0011 << off;
        ent_data = {2{st_data[15:0]}};
      end
      2'b10:   illegal = (off != 2'b00);
      default: illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      mis_q <= accept && illegal;
    end
  end

  // Payload storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr_q[wptr_q] <= ent_addr;
      buf_data_q[wptr_q] <= ent_data;
      buf_strb_q[wptr_q] <= ent_strb;
    end
  end

  always_comb begin
    rd_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rel[i]         = PTR_W'(i) - rptr_q;
      entry_valid[i] = ({1'b0, rel[i]} < count_q);
      if (entry_valid[i] && buf_addr_q[i] == rd_word) rd_hazard = 1'b1;
    end
  end

  assign wr_addr       = empty ? '0 : buf_addr_q[rptr_q];
  assign wr_data       = empty ? '0 : buf_data_q[rptr_q];
  assign wr_strb       = empty ? '0 : buf_strb_q[rptr_q];
  assign st_misaligned = mis_q;
  assign count         = count_q;

endmodule
`default_nettype wire

// File: doc/mem_write_ctrl.md
Name: mem_write_ctrl

Overview:
- Write-side controller for data memory; it is the write-direction counterpart of the memory read port.
- Accepts store requests from the core's memory stage over a valid/ready handshake.
- Aligns store data into byte lanes with byte strobes, and buffers stores in a DEPTH-entry FIFO.
- Drains one entry per accepted memory write beat.
- Flags read-after-write hazards against the read port address.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, memory word width. Only 32 is supported; any other value is an elaboration error.
- DEPTH, 4, store buffer entries. Must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- st_valid  in  1  store request valid.
- st_ready  out  1  store buffer can accept.
- st_addr  in  ADDR_WIDTH  store byte address.
- st_data  in  DATA_WIDTH  store data, right-justified.
- st_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- st_misaligned  out  1  one-cycle error pulse for a rejected store.
- wr_en  out  1  memory write valid.
- wr_ready  in  1  memory accepts write this cycle.
- wr_addr  out  ADDR_WIDTH  word-aligned write address.
- wr_data  out  DATA_WIDTH  lane-aligned write data.
- wr_strb  out  DATA_WIDTH/8  byte enables.
- rd_addr  in  ADDR_WIDTH  current read-port address (snooped).
- rd_hazard  out  1  a buffered store targets the word at rd_addr.
- empty  out  1  buffer empty.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (async assert, sync deassert):
  - count = 0, empty = 1, wr_en = 0, wr_addr/wr_data/wr_strb = 0, st_misaligned = 0.
  - Read/write pointers = 0. All buffered stores are discarded, including on reset mid-drain.
- st_ready = (count < DEPTH). It is combinational from count only and does not depend on wr_ready. A full buffer with a same-cycle pop still shows st_ready = 0.
- Accept condition: st_valid && st_ready. The inputs are sampled only on that edge.
- Misalignment rules:
  - Illegal when: half and st_addr[0] = 1; word and st_addr[1:0] != 0; or st_size = 11.
  - An illegal store completes the handshake but is not enqueued.
  - st_misaligned = 1 for exactly the next cycle.
- Lane alignment, with off = st_addr[1:0]:
  - byte: strb = 4'b0001 << off; data byte replicated to all 4 lanes.
  - half: strb = 4'b0011 << off; data halfword replicated to both halves.
  - word: strb = 4'b1111; data unchanged.
  - Stored entry address = {st_addr[ADDR_WIDTH-1:2], 2'b00}.
- Drain side:
  - wr_en = !empty. wr_addr/wr_data/wr_strb present the head entry.
  - wr_strb = 0 whenever wr_en = 0.
  - A pop occurs when wr_en && wr_ready. Outputs are held stable while wr_en && !wr_ready.
- Latency: a store accepted at edge N is first visible on wr_en in the cycle after edge N. There is no combinational bypass.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Ordering: strictly FIFO. No write merging.
- Pointers wrap modulo DEPTH. full = (count == DEPTH).
- rd_hazard (combinational):
  - 1 if any valid entry has a word address equal to {rd_addr[ADDR_WIDTH-1:2], 2'b00}.
  - Strobes are ignored (conservative).
  - The entry being popped in the current cycle still counts.
  - An incoming store in the same cycle does not count.
- empty = (count == 0). count is registered.

Test Plan:
1. Reset, then SW addr 0x100 data 0xDEADBEEF, wr_ready = 1 → next cycle wr_en = 1, wr_addr = 0x100, wr_data = 0xDEADBEEF, wr_strb = 1111; following cycle empty = 1, count = 0.
2. SB addr 0x203 data 0x000000A5, then SH addr 0x202 data 0x00001234 → first beat strb = 1000 with wr_data[31:24] = 0xA5; second beat strb = 1100 with wr_data[31:16] = 0x1234; both wr_addr = 0x200, in order.
3. Hold wr_ready = 0, issue 5 SW to 0x0, 0x4, 0x8, 0xC, 0x10 (DEPTH = 4) → st_ready drops after the 4th accept, count = 4, outputs stable at 0x0. Release wr_ready → drains 0x0, 0x4, 0x8, 0xC in order, then the 5th store is accepted; pointers wrap correctly.
4. SH addr 0x101, then SW addr 0x102, then st_size = 11 → three single-cycle st_misaligned pulses, count stays 0, wr_en never asserts.
5. Buffer holds SW 0x40 with wr_ready = 0; rd_addr = 0x43 → rd_hazard = 1. rd_addr = 0x44 → rd_hazard = 0. After the pop completes → rd_hazard = 0.
6. Buffer holds 3 entries and wr_en = 1; assert rst_n = 0 mid-cycle → wr_en, count and wr_strb go to 0 immediately (async). After release no stale writes appear.
